gpio_nios_entree: RTL and testbench

- Avalon-MM slave input PIO. It is the receive-side counterpart of the team's output PIO on the same Nios II system bus.
- Samples an external WIDTH-bit input bus through a synchronizer and exposes the data to software.
- Captures edges per bit into a sticky edge-capture register.
- Raises a maskable interrupt request to the Nios II.

---
 rtl/gpio_nios_entree.sv | 99 +++++++++
 tb/tb_gpio_nios_entree.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_nios_entree.sv
// Avalon-MM input PIO for the Nios II bus: synchronized input data, sticky
// per-bit edge capture (write-1-to-clear) and a maskable interrupt request.
module gpio_nios_entree #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_TYPE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic [31:0]      rd_next;

    assign wr_en = chipselect & ~write_n;
    assign rise  = sync2 & ~prev;
    assign fall  = ~sync2 & prev;

    always_comb begin
        if (EDGE_TYPE == 0)
            edge_bits = rise;
        else if (EDGE_TYPE == 1)
            edge_bits = fall;
        else
            edge_bits = rise | fall;
    end

    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Two-flop synchronizer; prev holds the last synchronized sample for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_mask <= '0;
        else if (wr_en && address == 2'd2)
            irq_mask <= writedata[WIDTH-1:0];
    end

    // A new edge wins over a same-cycle software clear of that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_capture <= '0;
        else
            edge_capture <= (edge_capture & ~clear_bits) | edge_bits;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = sync2;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

    generate
        if (IRQ_TYPE == 0) begin : g_irq_level
            assign irq = |(sync2 & irq_mask);
        end else begin : g_irq_edge
            assign irq = |(edge_capture & irq_mask);
        end
    endgenerate

endmodule

// File: tb/tb_gpio_nios_entree.sv
// Directed bench for gpio_nios_entree: three instances share one bus
// (rising/edge-irq, falling/edge-irq, any-edge/level-irq).
module tb_gpio_nios_entree;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_r, rd_f, rd_a;
    logic        irq_r, irq_f, irq_a;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_nios_entree #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));

    gpio_nios_entree #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));

    gpio_nios_entree #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Present the address; returns at the negedge after the capturing posedge.
    task automatic bus_read(input logic [1:0] a);
        @(negedge clk);
        address = a;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;

        // reset with inputs high
        repeat (3) @(negedge clk);
        check("reset_rd_r", rd_r, 32'h0);
        check("reset_irq_r", {31'h0, irq_r}, 32'h0);
        check("reset_irq_a", {31'h0, irq_a}, 32'h0);
        reset_n = 1'b1;
        settle();
        bus_read(2'd0);
        check("post_reset_data", rd_r, 32'h0000_00FF);
        bus_read(2'd3);
        check("post_reset_cap_r", rd_r, 32'h0000_00FF);
        check("post_reset_cap_f", rd_f, 32'h0000_0000);
        check("post_reset_cap_a", rd_a, 32'h0000_00FF);

        // drop all inputs, then clear everything
        in_port = 8'h00;
        settle();
        bus_read(2'd3);
        check("fall_all_cap_f", rd_f, 32'h0000_00FF);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3);
        check("clear_all_r", rd_r, 32'h0);
        check("clear_all_a", rd_a, 32'h0);

        // rising capture with edge irq, latency checked cycle by cycle
        bus_write(2'd2, 32'h0000_0004);
        @(negedge clk);
        in_port = 8'h05;
        @(negedge clk);
        check("lvl_irq_a_k", {31'h0, irq_a}, 32'h0);
        @(negedge clk);
        check("edge_irq_r_k1", {31'h0, irq_r}, 32'h0);
        check("lvl_irq_a_k1", {31'h0, irq_a}, 32'h1);
        @(negedge clk);
        check("edge_irq_r_k2", {31'h0, irq_r}, 32'h1);
        check("edge_irq_f_k2", {31'h0, irq_f}, 32'h0);
        bus_read(2'd3);
        check("rise_cap_r", rd_r, 32'h0000_0005);
        check("rise_cap_f", rd_f, 32'h0000_0000);
        check("rise_cap_a", rd_a, 32'h0000_0005);
        bus_write(2'd3, 32'h0000_0004);
        check("w1c_irq_r", {31'h0, irq_r}, 32'h0);
        bus_read(2'd3);
        check("w1c_partial_r", rd_r, 32'h0000_0001);
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd3);
        check("w1c_rest_r", rd_r, 32'h0);

        // set beats clear when an edge and a write-1 land on the same edge
        in_port = 8'h04;
        settle();
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd3);
        check("pre_sim_cap_f", rd_f, 32'h0);
        @(negedge clk);
        in_port = 8'h05;
        @(negedge clk);
        @(negedge clk);
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h0000_0001;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("sim_read_pre_edge_r", rd_r, 32'h0);
        @(negedge clk);
        check("sim_set_wins_r", rd_r, 32'h0000_0001);
        check("sim_set_wins_a", rd_a, 32'h0000_0001);
        check("sim_no_rise_f", rd_f, 32'h0);
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd3);
        check("sim_clear_r", rd_r, 32'h0);
        check("sim_clear_a", rd_a, 32'h0);

        // bit 3 up then down: falling vs any
        in_port = 8'h0D;
        settle();
        bus_read(2'd3);
        check("b3_up_r", rd_r, 32'h0000_0008);
        check("b3_up_f", rd_f, 32'h0);
        check("b3_up_a", rd_a, 32'h0000_0008);
        bus_write(2'd3, 32'h0000_0008);
        in_port = 8'h05;
        settle();
        bus_read(2'd3);
        check("b3_down_r", rd_r, 32'h0);
        check("b3_down_f", rd_f, 32'h0000_0008);
        check("b3_down_a", rd_a, 32'h0000_0008);

        // level irq on bit 7
        bus_write(2'd2, 32'h0000_0080);
        in_port = 8'h85;
        settle();
        check("lvl_irq_a_on", {31'h0, irq_a}, 32'h1);
        in_port = 8'h05;
        @(negedge clk);
        check("lvl_irq_a_hold", {31'h0, irq_a}, 32'h1);
        @(negedge clk);
        check("lvl_irq_a_off", {31'h0, irq_a}, 32'h0);
        settle();
        bus_read(2'd3);
        check("lvl_cap_a", rd_a, 32'h0000_0088);
        check("lvl_cap_r", rd_r, 32'h0000_0080);
        check("lvl_cap_f", rd_f, 32'h0000_0088);
        check("mask_irq_r_on", {31'h0, irq_r}, 32'h1);
        bus_write(2'd2, 32'h0);
        check("mask_irq_r_off", {31'h0, irq_r}, 32'h0);

        // register map
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check("reserved_reads_0", rd_r, 32'h0);
        bus_write(2'd0, 32'h0000_00FF);
        bus_read(2'd0);
        check("data_ro", rd_r, 32'h0000_0005);
        bus_write(2'd2, 32'hFFFF_FF3C);
        bus_read(2'd2);
        check("mask_upper_zero", rd_r, 32'h0000_003C);
        bus_read(2'd0);
        address = 2'd2;
        #1;
        check("rd_latency_before", rd_r, 32'h0000_0005);
        @(posedge clk);
        #1;
        check("rd_latency_after", rd_r, 32'h0000_003C);

        // asynchronous reset mid-operation
        @(negedge clk);
        address = 2'd3;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd_f", rd_f, 32'h0);
        check("async_rst_irq_r", {31'h0, irq_r}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd2);
        check("rst_mask_lost", rd_r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
